// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_pkg
// Description : Shared grid encoding and grid-memory requester indices.
// Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    localparam int GRID_AW      = 8;
    localparam int GRID_DW      = 8;
    localparam int ACTIVE_BIT   = 7;
    localparam int NUM_GRID_REQ = 3;

    localparam int REQ_VGA    = 0;
    localparam int REQ_PLACER = 1;
    localparam int REQ_MOVER  = 2;

    typedef enum logic [3:0] {
        BLOCK_AIR    = 4'h0,
        BLOCK_I      = 4'h1,
        BLOCK_O      = 4'h2,
        BLOCK_T      = 4'h3,
        BLOCK_S      = 4'h4,
        BLOCK_Z      = 4'h5,
        BLOCK_J      = 4'h6,
        BLOCK_L      = 4'h7,
        BLOCK_BORDER = 4'hF
    } block_e;

    // Cell layout: active flag on top, block code in the low nibble.
    function automatic logic [GRID_DW-1:0] grid_cell(input logic active, input block_e code);
        return {active, 3'b000, code};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational one-hot round-robin picker with exclusion mask
//               and optional fixed priority for requester 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] excl,
    input  logic [PW-1:0]    ptr,
    input  logic             prio0_en,
    output logic [N_REQ-1:0] pick
);

    logic [N_REQ-1:0] w_elig;
    logic [PW:0]      w_sum;
    logic [PW-1:0]    w_idx;
    logic             w_found;

    assign w_elig = req & ~excl;

    // Scan starts just after ptr so the previous owner is considered last.
    always_comb begin
        pick    = '0;
        w_sum   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        if (prio0_en && w_elig[0]) begin
            pick[0] = 1'b1;
        end else begin
            for (int i = 1; i <= N_REQ; i++) begin
                w_sum = {1'b0, ptr} + (PW+1)'(i);
                if (w_sum >= (PW+1)'(N_REQ)) begin
                    w_sum = w_sum - (PW+1)'(N_REQ);
                end
                w_idx = w_sum[PW-1:0];
                if (!w_found && w_elig[w_idx]) begin
                    pick[w_idx] = 1'b1;
                    w_found     = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/grid_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : grid_mem_arbiter
// Description : Single-port grid RAM arbiter with lockable bursts, bounded
//               hold time and registered one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
module grid_mem_arbiter
    import tetris_pkg::*;
#(
    parameter int N_REQ    = NUM_GRID_REQ,
    parameter int AW       = GRID_AW,
    parameter int DW       = GRID_DW,
    parameter int MAX_HOLD = 16,
    parameter int PRIO0    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    lock,
    input  logic [N_REQ-1:0]    we,
    input  logic [N_REQ*AW-1:0] addr,
    input  logic [N_REQ*DW-1:0] wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    output logic [DW-1:0]       rdata,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    output logic                mem_we,
    input  logic [DW-1:0]       mem_rdata
);

    localparam int c_PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_OWN  = 1'b1;

    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(MAX_HOLD - 1);

    logic [0:0]       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_rvalid;
    logic [c_PW-1:0]  r_rr_ptr;
    logic [c_HW-1:0]  r_hold_cnt;
    logic [AW-1:0]    r_last_addr;
    logic [DW-1:0]    r_last_wdata;

    logic [N_REQ-1:0] w_gnt_live;
    logic             w_own_req;
    logic             w_own_lock;
    logic             w_own_we;
    logic             w_beat;
    logic             w_locked;
    logic             w_others;
    logic             w_hold_last;
    logic             w_force;
    logic             w_arb;
    logic [AW-1:0]    w_own_addr;
    logic [DW-1:0]    w_own_wdata;
    logic [N_REQ-1:0] w_excl;
    logic [N_REQ-1:0] w_pick;
    logic [c_PW-1:0]  w_pick_idx;

    // Reset suppresses the grant in the same cycle so no beat can slip out.
    assign w_gnt_live  = (reset || r_state != c_ST_OWN) ? '0 : r_gnt;
    assign w_own_req   = |(w_gnt_live & req);
    assign w_own_lock  = |(r_gnt & lock);
    assign w_own_we    = |(r_gnt & we);
    assign w_beat      = w_own_req;
    assign w_locked    = (r_state == c_ST_OWN) & w_beat & w_own_lock;
    assign w_others    = |(req & ~r_gnt);
    assign w_hold_last = (r_hold_cnt == c_HOLD_LAST);
    assign w_force     = w_locked & w_hold_last & w_others;
    assign w_arb       = ~w_locked | w_force;
    assign w_excl      = w_force ? r_gnt : '0;

    always_comb begin
        w_own_addr  = '0;
        w_own_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_gnt[i]) begin
                w_own_addr  = addr[i*AW +: AW];
                w_own_wdata = wdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) begin
                w_pick_idx = c_PW'(i);
            end
        end
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (c_PW)
    ) u_rr_pick (
        .req      (req),
        .excl     (w_excl),
        .ptr      (r_rr_ptr),
        .prio0_en (PRIO0 != 0),
        .pick     (w_pick)
    );

    assign gnt       = w_gnt_live;
    assign rvalid    = reset ? '0 : r_rvalid;
    assign rdata     = mem_rdata;
    assign mem_we    = w_beat & w_own_we;
    assign mem_addr  = w_beat ? w_own_addr  : r_last_addr;
    assign mem_wdata = w_beat ? w_own_wdata : r_last_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_gnt        <= '0;
            r_rvalid     <= '0;
            r_rr_ptr     <= '0;
            r_hold_cnt   <= '0;
            r_last_addr  <= '0;
            r_last_wdata <= '0;
        end else begin
            r_rvalid <= (w_beat && !w_own_we) ? r_gnt : '0;
            if (w_beat) begin
                r_last_addr  <= w_own_addr;
                r_last_wdata <= w_own_wdata;
            end
            if (w_arb) begin
                r_gnt      <= w_pick;
                r_hold_cnt <= '0;
                if (|w_pick) begin
                    r_state  <= c_ST_OWN;
                    r_rr_ptr <= w_pick_idx;
                end else begin
                    r_state  <= c_ST_IDLE;
                end
            end else if (!w_hold_last) begin
                r_hold_cnt <= r_hold_cnt + c_HW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_grid_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_grid_mem_arbiter
// Description : Self-checking bench; two arbiters (PRIO0=1 / PRIO0=0) share
//               stimulus and are compared against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grid_mem_arbiter;

    localparam int MH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req, lock, we;
    logic [23:0] addr, wdata;

    logic [2:0]  gnt_o    [2];
    logic [2:0]  rvalid_o [2];
    logic [7:0]  rdata_o  [2];
    logic [7:0]  maddr    [2];
    logic [7:0]  mwdata   [2];
    logic        mwe      [2];

    int n_checks = 0;
    int n_pass   = 0;

    int         m_owner [2];
    int         m_ptr   [2];
    int         m_hold  [2];
    logic [2:0] m_rv    [2];
    logic [7:0] m_rd    [2];
    logic [7:0] m_last_a[2];
    logic [7:0] m_last_w[2];
    logic [7:0] shadow  [2][256];

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int a);
        if (a == 17) return 8'h83;
        return 8'(a * 29 + 3);
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [7:0] ram [256];
        logic [7:0] rd_q;

        grid_mem_arbiter #(
            .N_REQ(3), .AW(8), .DW(8), .MAX_HOLD(MH), .PRIO0(1 - gi)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req       (req),
            .lock      (lock),
            .we        (we),
            .addr      (addr),
            .wdata     (wdata),
            .gnt       (gnt_o[gi]),
            .rvalid    (rvalid_o[gi]),
            .rdata     (rdata_o[gi]),
            .mem_addr  (maddr[gi]),
            .mem_wdata (mwdata[gi]),
            .mem_we    (mwe[gi]),
            .mem_rdata (rd_q)
        );

        initial for (int a = 0; a < 256; a++) ram[a] = init_val(a);

        always @(posedge clk) begin
            if (mwe[gi]) ram[maddr[gi]] <= mwdata[gi];
            rd_q <= ram[maddr[gi]];
        end
    end

    task automatic check(input int d, input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL dut%0d %s: got %0h, expected %0h at %0t", d, tag, got, exp, $time);
    endtask

    // Winner: requester 0 if prioritised, else first requester after ptr (ptr itself last).
    function automatic int pick(input bit prio, input int excl, input int ptr, input logic [2:0] r);
        if (prio && r[0] && excl != 0) return 0;
        for (int i = 1; i <= 3; i++) begin
            int j;
            j = (ptr + i) % 3;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    task automatic eval_dut(input int d);
        int         k, w;
        bit         beat, locked, others;
        logic [7:0] a, wd;
        logic [2:0] kmask;
        k = m_owner[d];
        if (reset) begin
            check(d, "gnt_in_reset",    32'(gnt_o[d]),    32'd0);
            check(d, "rvalid_in_reset", 32'(rvalid_o[d]), 32'd0);
            check(d, "we_in_reset",     32'(mwe[d]),      32'd0);
            m_owner[d]  = -1;
            m_ptr[d]    = 0;
            m_hold[d]   = 0;
            m_rv[d]     = '0;
            m_last_a[d] = '0;
            m_last_w[d] = '0;
        end else begin
            kmask  = (k >= 0) ? 3'(1 << k) : 3'b000;
            beat   = (k >= 0) && req[k];
            a      = beat ? addr[k*8 +: 8]  : m_last_a[d];
            wd     = beat ? wdata[k*8 +: 8] : m_last_w[d];
            check(d, "gnt",       32'(gnt_o[d]),    32'(kmask));
            check(d, "rvalid",    32'(rvalid_o[d]), 32'(m_rv[d]));
            if (m_rv[d] != 3'b000) check(d, "rdata", 32'(rdata_o[d]), 32'(m_rd[d]));
            check(d, "mem_we",    32'(mwe[d]),      32'(beat && we[k]));
            check(d, "mem_addr",  32'(maddr[d]),    32'(a));
            check(d, "mem_wdata", 32'(mwdata[d]),   32'(wd));

            m_rv[d] = (beat && !we[k]) ? kmask : 3'b000;
            if (beat) begin
                m_rd[d] = shadow[d][a];
                if (we[k]) shadow[d][a] = wd;
                m_last_a[d] = a;
                m_last_w[d] = wd;
            end
            locked = beat && lock[k];
            others = (req & ~kmask) != 3'b000;
            if (locked && !(m_hold[d] == MH - 1 && others)) begin
                if (m_hold[d] < MH - 1) m_hold[d]++;
            end else begin
                w = pick(d == 0, locked ? k : -1, m_ptr[d], req);
                m_hold[d]  = 0;
                m_owner[d] = w;
                if (w >= 0) m_ptr[d] = w;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        eval_dut(0);
        eval_dut(1);
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w);
        req  = r;
        lock = l;
        we   = w;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(3'b000, 3'b000, 3'b000);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int  run[2];
        bit  dropped[2];
        int  dens[3];
        bit  lk[3];

        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 256; a++) shadow[d][a] = init_val(a);
        addr  = '0;
        wdata = '0;

        // Reset with every request held, then first grant after release.
        reset = 1'b1;
        set_in(3'b111, 3'b000, 3'b000);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check(0, "t1_first_gnt", 32'(gnt_o[0]), 32'h1);
        check(1, "t1_first_gnt", 32'(gnt_o[1]), 32'h2);

        // Single read of a known cell.
        do_reset();
        set_in(3'b010, 3'b000, 3'b000);
        addr[8 +: 8] = 8'd17;
        tick();
        tick();
        check(0, "t2_rvalid", 32'(rvalid_o[0]), 32'h2);
        check(0, "t2_rdata",  32'(rdata_o[0]),  32'h83);

        // Two unlocked requesters alternate.
        do_reset();
        set_in(3'b110, 3'b000, 3'b000);
        tick();
        check(1, "t3_alt0", 32'(gnt_o[1]), 32'h2);
        tick();
        check(1, "t3_alt1", 32'(gnt_o[1]), 32'h4);
        tick();
        check(1, "t3_alt2", 32'(gnt_o[1]), 32'h2);
        for (int i = 0; i < 4; i++) tick();

        // Locked read-check-clear-write burst with requester 0 waiting.
        do_reset();
        set_in(3'b100, 3'b100, 3'b000);
        addr[16 +: 8] = 8'd5;
        tick();
        set_in(3'b101, 3'b100, 3'b000);
        tick();
        addr[16 +: 8] = 8'd17;
        tick();
        set_in(3'b101, 3'b100, 3'b100);
        addr[16 +: 8]  = 8'd5;
        wdata[16 +: 8] = 8'h00;
        tick();
        set_in(3'b101, 3'b000, 3'b100);
        addr[16 +: 8]  = 8'd17;
        wdata[16 +: 8] = 8'h83;
        tick();
        check(0, "t4_gnt_after_lock", 32'(gnt_o[0]), 32'h1);
        check(1, "t4_gnt_after_lock", 32'(gnt_o[1]), 32'h1);

        // Lock held far past MAX_HOLD with another requester pending.
        do_reset();
        set_in(3'b010, 3'b010, 3'b000);
        tick();
        set_in(3'b110, 3'b010, 3'b000);
        run     = '{0, 0};
        dropped = '{0, 0};
        for (int c = 0; c < 40; c++) begin
            for (int d = 0; d < 2; d++) begin
                if (!dropped[d]) begin
                    if (gnt_o[d] == 3'b010) run[d]++;
                    else dropped[d] = 1'b1;
                end
            end
            tick();
        end
        check(0, "t5_locked_beats", 32'(run[0]), 32'd16);
        check(1, "t5_locked_beats", 32'(run[1]), 32'd16);

        // Reset in the middle of a locked write burst.
        do_reset();
        set_in(3'b010, 3'b010, 3'b010);
        addr[8 +: 8]  = 8'd9;
        wdata[8 +: 8] = 8'h55;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_in(3'b110, 3'b000, 3'b000);
        tick();
        check(0, "t6_gnt_after_reset", 32'(gnt_o[0]), 32'h2);
        check(1, "t6_gnt_after_reset", 32'(gnt_o[1]), 32'h2);

        // Randomized traffic with persistent locks and varying request density.
        lk = '{0, 0, 0};
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                for (int j = 0; j < 3; j++) begin
                    case ($urandom_range(0, 3))
                        0:       dens[j] = 0;
                        1:       dens[j] = 30;
                        2:       dens[j] = 90;
                        default: dens[j] = 100;
                    endcase
                end
            end
            for (int j = 0; j < 3; j++) begin
                if ($urandom_range(0, 23) == 0) lk[j] = !lk[j];
                req[j]          = ($urandom_range(0, 99) < dens[j]);
                lock[j]         = lk[j];
                we[j]           = 1'($urandom_range(0, 1));
                addr[j*8 +: 8]  = 8'($urandom_range(0, 15));
                wdata[j*8 +: 8] = 8'($urandom);
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
